// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_sequencer
//  Purpose  : Per-frame scheduler for the vector-field renderer. Clears the
//             back framebuffer, kicks the line-drawing engine, waits for it to
//             finish, then swaps front/back buffers on the next display frame
//             tick. Owns the framebuffer write port and shares it between the
//             internal clear walker and the draw engine's write stream.
//  Revision : 1.0  initial release
// ============================================================================
module frame_sequencer #(
    parameter int DRAW_WIDTH  = 320,
    parameter int DRAW_HEIGHT = 240,
    parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
    parameter int DRAW_DATAW  = 1,
    parameter int FCOUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  frame_tick,
    output logic                  draw_start,
    input  logic                  draw_done,
    input  logic [DRAW_ADDRW-1:0] draw_addr_in,
    input  logic [DRAW_DATAW-1:0] draw_data_in,
    output logic                  fb_we,
    output logic                  fb_bank,
    output logic [DRAW_ADDRW-1:0] fb_addr_write,
    output logic [DRAW_DATAW-1:0] fb_data_in,
    output logic                  front_sel,
    output logic                  busy,
    output logic [FCOUNT_W-1:0]   frame_count,
    output logic                  overrun
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_CLEAR     = 2'd1;
    localparam logic [1:0] c_ST_DRAW      = 2'd2;
    localparam logic [1:0] c_ST_WAIT_SWAP = 2'd3;

    // Address of the final pixel of a buffer; reaching it ends the clear.
    localparam logic [DRAW_ADDRW-1:0] c_LAST_ADDR = DRAW_ADDRW'(DRAW_SIZE - 1);

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic [1:0]            state_q,       state_d;
    logic [DRAW_ADDRW-1:0] clear_addr_q,  clear_addr_d;
    logic                  draw_start_q,  draw_start_d;
    logic                  fb_we_q,       fb_we_d;
    logic                  fb_bank_q;
    logic [DRAW_ADDRW-1:0] fb_addr_q,     fb_addr_d;
    logic [DRAW_DATAW-1:0] fb_data_q,     fb_data_d;
    logic                  front_sel_q;
    logic [FCOUNT_W-1:0]   frame_count_q;
    logic                  overrun_q;

    // Decoded per-cycle events
    logic                  w_swap;        // accepted tick: flip buffers this cycle
    logic                  w_overrun_set; // tick arrived before the frame was ready

    // State register and clear-walker address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_ST_IDLE;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Next-state logic: clear -> draw -> wait for tick -> swap -> next frame
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            c_ST_IDLE: begin
                if (enable) begin
                    state_d      = c_ST_CLEAR;
                    clear_addr_d = '0;
                end
            end
            c_ST_CLEAR: begin
                if (clear_addr_q == c_LAST_ADDR) begin
                    state_d      = c_ST_DRAW;
                    clear_addr_d = '0;
                end else begin
                    clear_addr_d = clear_addr_q + DRAW_ADDRW'(1);
                end
            end
            c_ST_DRAW: begin
                if (draw_done) begin
                    // A tick coinciding with done is honoured immediately.
                    if (frame_tick) begin
                        state_d      = enable ? c_ST_CLEAR : c_ST_IDLE;
                        clear_addr_d = '0;
                    end else begin
                        state_d = c_ST_WAIT_SWAP;
                    end
                end
            end
            c_ST_WAIT_SWAP: begin
                if (frame_tick) begin
                    // A dropped enable lets the current frame finish, then parks.
                    state_d      = enable ? c_ST_CLEAR : c_ST_IDLE;
                    clear_addr_d = '0;
                end
            end
            default: begin
                state_d      = c_ST_IDLE;
                clear_addr_d = '0;
            end
        endcase
    end

    // Output decode: write-port arbitration by state, swap and overrun events
    always_comb begin
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        draw_start_d  = 1'b0;
        w_swap        = 1'b0;
        w_overrun_set = 1'b0;
        case (state_q)
            c_ST_CLEAR: begin
                fb_we_d       = 1'b1;
                fb_addr_d     = clear_addr_q;
                fb_data_d     = '0;
                draw_start_d  = (clear_addr_q == c_LAST_ADDR);
                w_overrun_set = frame_tick;
            end
            c_ST_DRAW: begin
                fb_we_d       = 1'b1;
                fb_addr_d     = draw_addr_in;
                fb_data_d     = draw_data_in;
                w_swap        = draw_done & frame_tick;
                w_overrun_set = frame_tick & ~draw_done;
            end
            c_ST_WAIT_SWAP: begin
                w_swap = frame_tick;
            end
            default: begin
                fb_we_d = 1'b0;
            end
        endcase
    end

    // Registered write port, buffer select, frame counter and sticky overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            draw_start_q  <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_bank_q     <= 1'b1;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            front_sel_q   <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            draw_start_q <= draw_start_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            // Bank is captured alongside each write from the pre-swap front
            // select, so a write can never land in the displayed buffer.
            if (fb_we_d) begin
                fb_bank_q <= ~front_sel_q;
            end
            if (w_swap) begin
                front_sel_q   <= ~front_sel_q;
                frame_count_q <= frame_count_q + FCOUNT_W'(1);
            end
            if (w_overrun_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign draw_start    = draw_start_q;
    assign fb_we         = fb_we_q;
    assign fb_bank       = fb_bank_q;
    assign fb_addr_write = fb_addr_q;
    assign fb_data_in    = fb_data_q;
    assign front_sel     = front_sel_q;
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_sequencer
//  Purpose  : Self-checking bench for frame_sequencer (4x2 framebuffer).
//             Stimulus pushes expected framebuffer writes (with the cycle they
//             must appear) into a queue; a negedge monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int SIZE = W * H;
    localparam int AW   = 3;
    localparam int DW   = 1;
    localparam int FW   = 16;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          frame_tick;
    logic          draw_start;
    logic          draw_done;
    logic [AW-1:0] draw_addr_in;
    logic [DW-1:0] draw_data_in;
    logic          fb_we;
    logic          fb_bank;
    logic [AW-1:0] fb_addr_write;
    logic [DW-1:0] fb_data_in;
    logic          front_sel;
    logic          busy;
    logic [FW-1:0] frame_count;
    logic          overrun;

    frame_sequencer #(
        .DRAW_WIDTH (W),
        .DRAW_HEIGHT(H),
        .DRAW_DATAW (DW),
        .FCOUNT_W   (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .draw_start   (draw_start),
        .draw_done    (draw_done),
        .draw_addr_in (draw_addr_in),
        .draw_data_in (draw_data_in),
        .fb_we        (fb_we),
        .fb_bank      (fb_bank),
        .fb_addr_write(fb_addr_write),
        .fb_data_in   (fb_data_in),
        .front_sel    (front_sel),
        .busy         (busy),
        .frame_count  (frame_count),
        .overrun      (overrun)
    );

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          bank;
    } wr_t;

    wr_t      exp_q[$];
    int       cyc      = 0;
    int       n_checks = 0;
    int       n_fail   = 0;

    // Reference model of the architectural state
    bit       m_front   = 1'b0;
    bit       m_overrun = 1'b0;
    bit [FW-1:0] m_count = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every write must match the oldest expected write in its cycle
    always @(negedge clk) begin
        wr_t w;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_write: addr %0d due cycle %0d not seen (now %0d)",
                     exp_q[0].addr, exp_q[0].due, cyc);
            void'(exp_q.pop_front());
        end
        if (fb_we === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(fb_addr_write), 32'(w.addr));
                check("wr_data", 32'(fb_data_in),    32'(w.data));
                check("wr_bank", 32'(fb_bank),       32'(w.bank));
            end else begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, expected none",
                         fb_addr_write, fb_data_in, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        draw_done    = 1'b0;
        frame_tick   = 1'b0;
        draw_addr_in = AW'($urandom_range(0, SIZE - 1));
        draw_data_in = DW'($urandom_range(0, 1));
    endtask

    task automatic check_reset(string tag);
        check({tag, "_draw_start"}, 32'(draw_start),    0);
        check({tag, "_fb_we"},      32'(fb_we),         0);
        check({tag, "_fb_bank"},    32'(fb_bank),       1);
        check({tag, "_fb_addr"},    32'(fb_addr_write), 0);
        check({tag, "_fb_data"},    32'(fb_data_in),    0);
        check({tag, "_front_sel"},  32'(front_sel),     0);
        check({tag, "_frame_cnt"},  32'(frame_count),   0);
        check({tag, "_overrun"},    32'(overrun),       0);
        check({tag, "_busy"},       32'(busy),          0);
    endtask

    // One frame. e = cycle in which the leave-IDLE/swap decision saw enable high;
    // current cycle is e (from IDLE) or e+1 (chained after a swap).
    task automatic run_frame(input int e, input int dlen, input int gap, input bit early,
                             input bit coincide, input bit drop_en, input int rst_at);
        bit exp_en;
        for (int i = 0; i < SIZE; i++)
            exp_q.push_back(wr_t'{due: e + 2 + i, addr: AW'(i), data: '0, bank: ~m_front});
        for (int k = 1; k <= SIZE; k++) begin
            if (cyc < e + k) step();
            check("busy_clear", 32'(busy), 1);
            check("draw_start_clear", 32'(draw_start), 0);
            if (early && k == 3) begin
                frame_tick = 1'b1;
                m_overrun  = 1'b1;
            end
        end
        step();
        check("draw_start_pulse", 32'(draw_start), 1);
        check("overrun_at_draw",  32'(overrun),    32'(m_overrun));
        check("front_at_draw",    32'(front_sel),  32'(m_front));
        for (int k = 0; k <= dlen; k++) begin
            if (k > 0) begin
                step();
                check("draw_start_once", 32'(draw_start), 0);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_reset("rst_mid_draw");
                m_front   = 1'b0;
                m_count   = '0;
                m_overrun = 1'b0;
                return;
            end
            exp_q.push_back(wr_t'{due: cyc + 1, addr: draw_addr_in, data: draw_data_in,
                                  bank: ~m_front});
            if (drop_en && k == dlen / 2) enable = 1'b0;
            if (k == dlen) begin
                draw_done = 1'b1;
                if (coincide) frame_tick = 1'b1;
            end
        end
        exp_en = enable;
        if (!coincide) begin
            for (int g = 1; g <= gap; g++) begin
                step();
                check("busy_wait",  32'(busy),      1);
                check("front_wait", 32'(front_sel), 32'(m_front));
            end
            frame_tick = 1'b1;
            exp_en     = enable;
        end
        step();
        m_front = ~m_front;
        m_count = m_count + 1'b1;
        check("front_after_swap", 32'(front_sel),   32'(m_front));
        check("count_after_swap", 32'(frame_count), 32'(m_count));
        check("overrun_at_swap",  32'(overrun),     32'(m_overrun));
        check("busy_after_swap",  32'(busy),        32'(exp_en));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        frame_tick   = 1'b0;
        draw_done    = 1'b0;
        draw_addr_in = '0;
        draw_data_in = '0;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;
        repeat (2) step();

        // Normal frame, then a chained frame whose clear targets bank 0
        enable = 1'b1;
        run_frame(cyc, 20, 5, 1'b0, 1'b0, 1'b0, -1);
        // Coincident done and tick
        run_frame(cyc - 1, int'($urandom_range(4, 12)), 1, 1'b0, 1'b1, 1'b0, -1);
        check("overrun_coincide", 32'(overrun), 0);
        // Early tick during clear
        run_frame(cyc - 1, int'($urandom_range(5, 15)), int'($urandom_range(1, 6)),
                  1'b1, 1'b0, 1'b0, -1);
        // Random back-to-back frames
        for (int i = 0; i < 4; i++)
            run_frame(cyc - 1, int'($urandom_range(3, 25)), int'($urandom_range(1, 8)),
                      1'b0, 1'($urandom_range(0, 1)), 1'b0, -1);
        // Drop enable mid-draw: frame completes, then idles
        run_frame(cyc - 1, 10, 3, 1'b0, 1'b0, 1'b1, -1);
        repeat (3) step();
        draw_done = 1'b1;
        step();
        repeat (4) begin
            step();
            check("stray_busy",  32'(busy),        0);
            check("stray_front", 32'(front_sel),   32'(m_front));
            check("stray_count", 32'(frame_count), 32'(m_count));
        end

        // Reset in the middle of DRAW, then restart from a clean clear
        enable = 1'b1;
        run_frame(cyc, 12, 2, 1'b0, 1'b0, 1'b0, 6);
        run_frame(cyc, 8, 2, 1'b0, 1'b0, 1'b1, -1);
        repeat (5) step();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
